// File: rtl/alu_operand_sequencer.sv
// Operand/OpCode entry and result capture for the Lab2 N-bit ALU, driven by one debounced button.
// Optional `ALU_SEQ_ACCUM_EN: a press in the result state chains the result into A.
module alu_operand_sequencer #(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SETTLE_CYCLES   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    input  logic [3:0]   op_sw,
    input  logic         btn,
    input  logic [N-1:0] alu_out,
    input  logic         alu_z,
    input  logic         alu_n,
    input  logic         alu_v,
    input  logic         alu_c,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [3:0]   op,
    output logic [N-1:0] res,
    output logic [3:0]   flags,
    output logic         res_valid,
    output logic         div0_err,
    output logic [2:0]   state
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned StW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // OpCodeEnum codes that need the divide-by-zero guard.
    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpDiv = 4'd3;
    localparam logic [3:0] OpMod = 4'd4;

    typedef enum logic [2:0] {
        StA    = 3'd0,
        StB    = 3'd1,
        StOp   = 3'd2,
        StExec = 3'd3,
        StShow = 3'd4
    } state_e;

    logic           btn_s1_q, btn_s2_q;
    logic           deb_q, deb_d, deb_prev_q;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           press;

    state_e         state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]     op_q, op_d, flags_q, flags_d;
    logic           res_valid_q, res_valid_d, div0_q, div0_d;
    logic [StW-1:0] settle_q, settle_d;
    logic           div0_hit;

    // Level must differ from the accepted one for DEBOUNCE_CYCLES samples in a row.
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        if (btn_s2_q != deb_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end
    end

    assign press    = deb_q & ~deb_prev_q;
    assign div0_hit = ((op_q == OpDiv) || (op_q == OpMod)) && (b_q == '0);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        flags_d     = flags_q;
        res_valid_d = res_valid_q;
        div0_d      = div0_q;
        settle_d    = settle_q;
        unique case (state_q)
            StA: begin
                if (press) begin
                    a_d     = sw;
                    state_d = StB;
                end
            end
            StB: begin
                if (press) begin
                    b_d     = sw;
                    state_d = StOp;
                end
            end
            StOp: begin
                if (press) begin
                    op_d     = op_sw;
                    settle_d = '0;
                    state_d  = StExec;
                end
            end
            StExec: begin
                if (settle_q == StW'(SETTLE_CYCLES - 1)) begin
                    res_d       = div0_hit ? '0 : alu_out;
                    flags_d     = div0_hit ? 4'b1000 : {alu_z, alu_n, alu_v, alu_c};
                    div0_d      = div0_hit;
                    res_valid_d = 1'b1;
                    state_d     = StShow;
                end else begin
                    settle_d = settle_q + StW'(1);
                end
            end
            StShow: begin
                if (press) begin
                    res_valid_d = 1'b0;
                    div0_d      = 1'b0;
`ifdef ALU_SEQ_ACCUM_EN
                    a_d         = res_q;
                    state_d     = StB;
`else
                    state_d     = StA;
`endif
                end
            end
            default: state_d = StA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            deb_q       <= 1'b0;
            deb_prev_q  <= 1'b0;
            db_cnt_q    <= '0;
            state_q     <= StA;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OpAdd;
            res_q       <= '0;
            flags_q     <= '0;
            res_valid_q <= 1'b0;
            div0_q      <= 1'b0;
            settle_q    <= '0;
        end else begin
            btn_s1_q    <= btn;
            btn_s2_q    <= btn_s1_q;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_q;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            res_valid_q <= res_valid_d;
            div0_q      <= div0_d;
            settle_q    <= settle_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign op        = op_q;
    assign res       = res_q;
    assign flags     = flags_q;
    assign res_valid = res_valid_q;
    assign div0_err  = div0_q;
    assign state     = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer; a behavioural ALU closes the loop on A/B/op.
module tb_alu_operand_sequencer;

    localparam int unsigned N      = 4;
    localparam int unsigned DEB    = 4;
    localparam int unsigned SETTLE = 2;

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpDiv = 4'd3;
    localparam logic [3:0] OpMod = 4'd4;
    localparam logic [3:0] OpBad = 4'hF;

    typedef struct packed {
        logic [3:0] res;
        logic [3:0] flags;
        logic       div0;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sw = '0;
    logic [3:0]   op_sw = '0;
    logic         btn = 1'b0;
    logic [N-1:0] alu_out;
    logic         alu_z, alu_n, alu_v, alu_c;
    logic [N-1:0] A, B, res;
    logic [3:0]   op, flags;
    logic         res_valid, div0_err;
    logic [2:0]   state;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_operand_sequencer #(
        .N(N), .DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .op_sw(op_sw), .btn(btn),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c),
        .A(A), .B(B), .op(op), .res(res), .flags(flags),
        .res_valid(res_valid), .div0_err(div0_err), .state(state)
    );

    // Behavioural ALU; divide by zero returns junk so the forced capture is visible.
    logic [4:0] wide;
    always_comb begin
        wide    = '0;
        alu_out = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OpAdd: begin
                wide    = {1'b0, A} + {1'b0, B};
                alu_out = wide[3:0];
                alu_c   = wide[4];
                alu_v   = (A[3] == B[3]) && (alu_out[3] != A[3]);
            end
            OpSub: begin
                wide    = {1'b0, A} + {1'b0, ~B} + 5'd1;
                alu_out = wide[3:0];
                alu_c   = wide[4];
                alu_v   = (A[3] != B[3]) && (alu_out[3] != A[3]);
            end
            OpDiv, OpMod: begin
                if (B == '0) begin
                    alu_out = 4'b1111;
                    alu_c   = 1'b1;
                    alu_v   = 1'b1;
                end else if (op == OpDiv) begin
                    alu_out = $signed(A) / $signed(B);
                end else begin
                    alu_out = $signed(A) % $signed(B);
                end
            end
            default: alu_out = A ^ B;
        endcase
        alu_z = (alu_out == '0);
        alu_n = alu_out[3];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops on each res_valid rise and checks value plus time spent in EXEC.
    int   exec_cnt = 0;
    logic rv_prev  = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            exec_cnt = 0;
            rv_prev  = 1'b0;
        end else begin
            if (state == 3'd3) exec_cnt++;
            if (res_valid && !rv_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_res_valid", 32'(res_valid), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("sb_res", 32'(res), 32'(e.res));
                    check("sb_flags", 32'(flags), 32'(e.flags));
                    check("sb_div0", 32'(div0_err), 32'(e.div0));
                    check("sb_exec_cycles", 32'(exec_cnt), 32'(SETTLE));
                end
                exec_cnt = 0;
            end
            rv_prev = res_valid;
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        btn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic press();
        btn = 1'b1;
        repeat (12) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] o,
                         input exp_t x);
        sw = a;
        press();
        check("state_after_a", 32'(state), 32'(1));
        check("a_loaded", 32'(A), 32'(a));
        sw = b;
        press();
        check("state_after_b", 32'(state), 32'(2));
        check("b_loaded", 32'(B), 32'(b));
        op_sw = o;
        sb.push_back(x);
        press();
        check("state_show", 32'(state), 32'(4));
        check("res_valid_show", 32'(res_valid), 32'(1));
        check("op_loaded", 32'(op), 32'(o));
    endtask

    task automatic exit_show(input logic [3:0] held_res);
        press();
        check("exit_res_valid", 32'(res_valid), 32'(0));
        check("exit_div0", 32'(div0_err), 32'(0));
`ifdef ALU_SEQ_ACCUM_EN
        check("exit_state_chain", 32'(state), 32'(1));
        check("exit_a_chain", 32'(A), 32'(held_res));
        reset_dut();
`else
        check("exit_state", 32'(state), 32'(0));
        check("exit_res_held", 32'(res), 32'(held_res));
`endif
    endtask

    initial begin
        bit seen;
        reset_dut();
        check("rst_state", 32'(state), 32'(0));
        check("rst_a", 32'(A), 32'(0));
        check("rst_b", 32'(B), 32'(0));
        check("rst_op", 32'(op), 32'(OpAdd));
        check("rst_res", 32'(res), 32'(0));
        check("rst_flags", 32'(flags), 32'(0));
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_div0", 32'(div0_err), 32'(0));

        // Short glitch rejected, long hold gives exactly one press.
        sw  = 4'b0011;
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_no_press", 32'(state), 32'(0));
        btn = 1'b1;
        repeat (20) @(negedge clk);
        check("hold_one_press", 32'(state), 32'(1));
        btn = 1'b0;
        repeat (12) @(negedge clk);
        check("hold_still_b", 32'(state), 32'(1));
        check("hold_a", 32'(A), 32'(4'b0011));
        reset_dut();

        do_op(4'b0011, 4'b0010, OpAdd, '{res: 4'b0101, flags: 4'b0000, div0: 1'b0});
        exit_show(4'b0101);
        do_op(4'b0111, 4'b0010, OpAdd, '{res: 4'b1001, flags: 4'b0110, div0: 1'b0});
        exit_show(4'b1001);
        do_op(4'b0110, 4'b0000, OpDiv, '{res: 4'b0000, flags: 4'b1000, div0: 1'b1});
        check("div0_set", 32'(div0_err), 32'(1));
        exit_show(4'b0000);
        do_op(4'b0110, 4'b0010, OpDiv, '{res: 4'b0011, flags: 4'b0000, div0: 1'b0});
        exit_show(4'b0011);
        do_op(4'b0111, 4'b0011, OpMod, '{res: 4'b0001, flags: 4'b0000, div0: 1'b0});
        exit_show(4'b0001);
        do_op(4'b1100, 4'b0011, OpBad, '{res: 4'b1111, flags: 4'b0100, div0: 1'b0});
        exit_show(4'b1111);

        // Reset one cycle into EXEC: nothing captured, everything back to reset values.
        reset_dut();
        sw = 4'b0101;
        press();
        sw = 4'b0001;
        press();
        op_sw = OpAdd;
        btn   = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (state == 3'd3) seen = 1'b1;
        end
        check("exec_reached", 32'(seen), 32'(1));
        rst = 1'b1;
        btn = 1'b0;
        @(negedge clk);
        check("midrst_state", 32'(state), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_state_after", 32'(state), 32'(0));
        check("midrst_res_valid", 32'(res_valid), 32'(0));
        check("midrst_a", 32'(A), 32'(0));
        check("midrst_b", 32'(B), 32'(0));
        check("midrst_res", 32'(res), 32'(0));
        check("midrst_flags", 32'(flags), 32'(0));

`ifdef ALU_SEQ_ACCUM_EN
        do_op(4'b0011, 4'b0010, OpAdd, '{res: 4'b0101, flags: 4'b0000, div0: 1'b0});
        press();
        check("chain_state", 32'(state), 32'(1));
        check("chain_a", 32'(A), 32'(4'b0101));
        check("chain_res_valid", 32'(res_valid), 32'(0));
        sw = 4'b0001;
        press();
        check("chain_state_op", 32'(state), 32'(2));
        op_sw = OpSub;
        sb.push_back('{res: 4'b0100, flags: 4'b0001, div0: 1'b0});
        press();
        check("chain_state_show", 32'(state), 32'(4));
`endif

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
